// File: rtl/bc_word_serializer.sv
// Word-to-serial framer: pops DATA_W-bit words over ready/valid and sends each as a framed, MSB-first bit stream.
// Optional even-parity bit after the data bits when BC_SER_PARITY_EN is defined.
module bc_word_serializer #(
  parameter int DATA_W       = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_rdy,
  output logic              ser_frame,
  output logic              ser_clk,
  output logic              ser_data,
  output logic              frame_done,
  output logic [15:0]       frames_sent
);

  localparam int PH_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLKS_PER_BIT - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(CLKS_PER_BIT / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
`ifdef BC_SER_PARITY_EN
    S_PARITY,
`endif
    S_GAP
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [PH_W-1:0]   r_phase;
  logic [BIT_W-1:0]  r_bit;
`ifdef BC_SER_PARITY_EN
  logic              r_parity;
`endif

  logic [PH_W-1:0] w_phase_nxt;
  logic            w_phase_last;
  logic            w_bit_last;
  logic            w_clk_nxt;

  assign w_phase_nxt  = r_phase + PH_W'(1);
  assign w_phase_last = (r_phase == PH_LAST);
  assign w_bit_last   = (r_bit == BIT_LAST);
  // Serial clock is low for the first half of a bit and high for the rest.
  assign w_clk_nxt    = (w_phase_nxt >= PH_HALF);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      // NOTE: the shift register is cleared too, so no stale word survives an aborted frame.
      r_shift     <= '0;
      r_phase     <= '0;
      r_bit       <= '0;
`ifdef BC_SER_PARITY_EN
      r_parity    <= 1'b0;
`endif
      in_rdy      <= 1'b1;
      ser_frame   <= 1'b0;
      ser_clk     <= 1'b0;
      ser_data    <= 1'b0;
      frame_done  <= 1'b0;
      frames_sent <= '0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift   <= in_data;
`ifdef BC_SER_PARITY_EN
            r_parity  <= ^in_data;
`endif
            r_phase   <= '0;
            in_rdy    <= 1'b0;
            ser_frame <= 1'b1;
            r_state   <= S_LEAD;
          end
        end

        S_LEAD: begin
          if (w_phase_last) begin
            r_phase  <= '0;
            r_bit    <= '0;
            ser_data <= r_shift[DATA_W-1];
            r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
            r_state  <= S_SHIFT;
          end else begin
            r_phase <= w_phase_nxt;
          end
        end

        S_SHIFT: begin
          if (w_phase_last) begin
            r_phase <= '0;
            ser_clk <= 1'b0;
            if (w_bit_last) begin
`ifdef BC_SER_PARITY_EN
              ser_data <= r_parity;
              r_state  <= S_PARITY;
`else
              ser_frame   <= 1'b0;
              ser_data    <= 1'b0;
              frame_done  <= 1'b1;
              frames_sent <= frames_sent + 16'd1;
              r_state     <= S_GAP;
`endif
            end else begin
              r_bit    <= r_bit + BIT_W'(1);
              ser_data <= r_shift[DATA_W-1];
              r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
            end
          end else begin
            r_phase <= w_phase_nxt;
            ser_clk <= w_clk_nxt;
          end
        end

`ifdef BC_SER_PARITY_EN
        S_PARITY: begin
          if (w_phase_last) begin
            r_phase     <= '0;
            ser_clk     <= 1'b0;
            ser_frame   <= 1'b0;
            ser_data    <= 1'b0;
            frame_done  <= 1'b1;
            frames_sent <= frames_sent + 16'd1;
            r_state     <= S_GAP;
          end else begin
            r_phase <= w_phase_nxt;
            ser_clk <= w_clk_nxt;
          end
        end
`endif

        S_GAP: begin
          if (w_phase_last) begin
            r_phase <= '0;
            in_rdy  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_phase <= w_phase_nxt;
          end
        end

        default: begin
          r_state <= S_IDLE;
          in_rdy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/bc_word_serializer.md
Name: bc_word_serializer

Overview:
- Downstream stage of the bidirectional controller/avoidance buffer.
- Pops 16-bit words from the buffer's avoidance-side output through a ready/valid handshake.
- Serializes each word into a framed, clocked bit stream (frame strobe, serial clock, serial data) for the avoidance processor link.
- One word per frame, MSB first. Keeps a wrapping count of completed frames.

Parameters:
- DATA_W, 16: word width; must match the buffer data width.
- CLKS_PER_BIT, 4: system clocks per serial bit. Must be even and ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  word from buffer (avoid_out_data).
- in_valid  in  1  buffer has a word available.
- in_rdy  out  1  serializer accepts a word this cycle; drives the buffer's avoid_out_rdy.
- ser_frame  out  1  high for the whole frame, from the lead bit through the last data/parity bit.
- ser_clk  out  1  serial clock; rising edge at mid-bit.
- ser_data  out  1  serial data.
- frame_done  out  1  one-cycle pulse when the last bit period ends.
- frames_sent  out  16  count of completed frames; wraps 0xFFFF→0x0000.

Behaviour:
- Reset (rst=1 at an edge):
  - Next cycle: state=IDLE, in_rdy=1, ser_frame=0, ser_clk=0, ser_data=0, frame_done=0, frames_sent=0.
  - Shift register and counters are cleared.
- All outputs are registered.
- FSM states:
  - IDLE: in_rdy=1, serial outputs 0. If in_valid=1 at an edge, capture in_data into the shift register, go to LEAD, drop in_rdy at the same edge. Handshake occurs only when in_valid&&in_rdy.
  - LEAD: CLKS_PER_BIT cycles. ser_frame=1, ser_data=0, ser_clk=0. Then SHIFT.
  - SHIFT: DATA_W bits, MSB first, each held CLKS_PER_BIT cycles. Within a bit: ser_clk=0 for the first CLKS_PER_BIT/2 cycles, 1 for the rest. ser_data is stable for the whole bit. After the last bit, go to GAP (or PARITY when enabled).
  - GAP: CLKS_PER_BIT cycles. ser_frame=0, ser_clk=0, ser_data=0. Then IDLE, with in_rdy=1 from the first IDLE cycle.
- frame_done pulses for exactly one cycle: the first GAP cycle. frames_sent increments on the same edge.
- Latency: accept edge → first LEAD cycle is the next cycle. Total from accept to in_rdy=1 is (DATA_W+2)*CLKS_PER_BIT cycles (72 at defaults). frame_done falls at cycle (DATA_W+1)*CLKS_PER_BIT+1 after accept.
- Boundary conditions:
  - in_valid while busy: ignored, no capture; upstream holds its word.
  - in_data changes after capture: no effect on the frame in progress.
  - Back-to-back: with in_valid held high, the next word is accepted on the first IDLE cycle. Minimum word period is (DATA_W+2)*CLKS_PER_BIT+1 cycles.
  - Reset mid-frame: the frame is aborted on the next edge and the word is lost; no frame_done; frames_sent=0.
  - Bit and clock-phase counters wrap cleanly; no partial bit at state boundaries.

Optional Feature:
- Macro: BC_SER_PARITY_EN.
- When defined: a PARITY state follows SHIFT. It lasts one bit period with the same ser_clk shape and ser_frame=1. ser_data = even parity (XOR of all DATA_W bits). Frame length becomes (DATA_W+3)*CLKS_PER_BIT; frame_done and frames_sent move to the end of PARITY.
- When undefined: no PARITY state and no parity logic.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release → in_rdy=1, ser_frame=0, ser_clk=0, ser_data=0, frame_done=0, frames_sent=0x0000.
- Single word 0xA5C3, CLKS_PER_BIT=4 → ser_data sampled on 16 ser_clk rises reads 1010_0101_1100_0011. frame_done pulses 69 cycles after accept. in_rdy=1 at cycle 72. frames_sent=1.
- Back-to-back words 0x000A..0x0013 (10 words), in_valid held → 10 frames, each 16 sampled bits matching its word. Accept edges 73 cycles apart. frames_sent=10.
- Reset mid-frame: assert rst during data bit 5 of 0xFFFF → next cycle ser_frame=0, in_rdy=1, frames_sent=0, no frame_done. A following word 0x1234 serializes correctly.
- Hold stability: change in_data to 0x0000 during a 0xBEEF frame; toggle in_valid while busy → transmitted bits still read 0xBEEF; only one handshake per frame.
- BC_SER_PARITY_EN defined:
  - 0x0001 → parity bit 1; 0x0003 → parity bit 0.
  - Frame length 76 cycles; frame_done at cycle 73.
